// File: rtl/button_pulse_gen_if.sv
// Push-button conditioning bundle: raw button and repeat enable in,
// debounced level and count pulse out.
interface button_pulse_gen_if;
    logic button_i;
    logic repeat_en_i;
    logic pressed_o;
    logic pulse_o;

    // Driver side (bench or upstream logic)
    modport master (
        output button_i,
        output repeat_en_i,
        input  pressed_o,
        input  pulse_o
    );

    // Conditioning block side
    modport slave (
        input  button_i,
        input  repeat_en_i,
        output pressed_o,
        output pulse_o
    );
endinterface

// File: rtl/button_pulse_gen.sv
// Turns a raw, bouncy push-button level into clean fixed-width count pulses,
// with optional auto-repeat while held. pulse_o is a bare flop output.
module button_pulse_gen #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned PULSE_CYCLES    = 2,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    button_pulse_gen_if.slave   bus
);

    localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int unsigned WID_W  = $clog2(PULSE_CYCLES + 1);
    localparam int unsigned MAX_IV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TMR_W  = $clog2(MAX_IV + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.button_i};
        end
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce: accept a level only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    // ------------------------------------------------------------------
    logic [DEB_W-1:0] deb_cnt_q;
    logic             pressed_q;
    logic             mismatch_c;
    logic             deb_hit_c;
    logic             pressed_nxt_c;
    logic             rise_c;
    logic             fall_c;

    always_comb begin
        mismatch_c    = btn_s ^ pressed_q;
        deb_hit_c     = mismatch_c && (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1));
        pressed_nxt_c = pressed_q ^ deb_hit_c;
        rise_c        = deb_hit_c && !pressed_q;
        fall_c        = deb_hit_c && pressed_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            deb_cnt_q <= '0;
            pressed_q <= 1'b0;
        end else begin
            pressed_q <= pressed_nxt_c;
            if (!mismatch_c || deb_hit_c) begin
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + DEB_W'(1);
            end
        end
    end

    assign bus.pressed_o = pressed_q;

    // ------------------------------------------------------------------
    // Pulse FSM
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_nxt;
    logic [WID_W-1:0] wid_cnt_q;
    logic [WID_W-1:0] wid_cnt_nxt;
    logic [TMR_W-1:0] rep_tmr_q;
    logic [TMR_W-1:0] rep_tmr_nxt;
    logic             first_q;
    logic             first_nxt;
    logic             pulse_q;
    logic             pulse_nxt;
    logic [TMR_W-1:0] rep_iv_c;
    logic             rep_trig_c;
    logic             start_c;
    logic             press_start_c;

    // Interval to the next repeat depends on whether one has been issued yet
    assign rep_iv_c   = first_q ? TMR_W'(REPEAT_DELAY) : TMR_W'(REPEAT_PERIOD);
    assign rep_trig_c = bus.repeat_en_i && (rep_tmr_q == rep_iv_c);

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; a release coinciding with a repeat trigger suppresses it
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_c) begin
                    state_nxt = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (wid_cnt_q == WID_W'(1)) begin
                    state_nxt = pressed_nxt_c ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (fall_c || !pressed_q) begin
                    state_nxt = ST_IDLE;
                end else if (rep_trig_c) begin
                    state_nxt = ST_PULSE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values, all registered below
    always_comb begin
        start_c       = (state_q != ST_PULSE) && (state_nxt == ST_PULSE);
        press_start_c = start_c && (state_q == ST_IDLE);
        pulse_nxt     = (state_nxt == ST_PULSE);
        wid_cnt_nxt   = '0;
        rep_tmr_nxt   = '0;
        first_nxt     = first_q;

        if (start_c) begin
            wid_cnt_nxt = WID_W'(PULSE_CYCLES);
        end else if ((state_q == ST_PULSE) && (state_nxt == ST_PULSE)) begin
            wid_cnt_nxt = wid_cnt_q - WID_W'(1);
        end

        if (!bus.repeat_en_i || press_start_c) begin
            first_nxt = 1'b1;
        end else if (start_c) begin
            first_nxt = 1'b0;
        end

        // Timer counts from the start of the last pulse; cleared while disabled
        if (!bus.repeat_en_i || (state_nxt == ST_IDLE)) begin
            rep_tmr_nxt = '0;
        end else if (start_c) begin
            rep_tmr_nxt = TMR_W'(1);
        end else if (rep_tmr_q != TMR_W'(MAX_IV)) begin
            rep_tmr_nxt = rep_tmr_q + TMR_W'(1);
        end else begin
            rep_tmr_nxt = rep_tmr_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wid_cnt_q <= '0;
            rep_tmr_q <= '0;
            first_q   <= 1'b1;
            pulse_q   <= 1'b0;
        end else begin
            wid_cnt_q <= wid_cnt_nxt;
            rep_tmr_q <= rep_tmr_nxt;
            first_q   <= first_nxt;
            pulse_q   <= pulse_nxt;
        end
    end

    assign bus.pulse_o = pulse_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen: debounce latency, bounce/glitch
// rejection, auto-repeat timing, async reset and repeat re-enable.
// Edge numbering: the button is driven just after edge t0; t0+1 is the first sampling edge.
module tb_button_pulse_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    button_pulse_gen_if bif ();

    button_pulse_gen dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record edges after which pulse/pressed rose or fell
    int   starts[$];
    int   rises[$];
    int   falls[$];
    int   hi_cnt = 0;
    logic prev_pulse = 1'b0;
    logic prev_pr = 1'b0;

    always @(negedge clk) begin
        if (bif.pulse_o === 1'b1) hi_cnt++;
        if (bif.pulse_o === 1'b1 && prev_pulse !== 1'b1) starts.push_back(cyc);
        if (bif.pressed_o === 1'b1 && prev_pr !== 1'b1) rises.push_back(cyc);
        if (bif.pressed_o === 1'b0 && prev_pr === 1'b1) falls.push_back(cyc);
        prev_pulse = bif.pulse_o;
        prev_pr    = bif.pressed_o;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        starts.delete();
        rises.delete();
        falls.delete();
        hi_cnt = 0;
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    int t0;
    int t1;
    int rr;

    initial begin
        bif.button_i    = 1'b0;
        bif.repeat_en_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pressed", int'(bif.pressed_o), 0);
        chk("reset_pulse", int'(bif.pulse_o), 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clear_mon();

        // 1: clean press, no repeat
        t0 = cyc;
        bif.button_i = 1'b1;
        wait_to(t0 + 17);
        chk("t1_pressed_e17", int'(bif.pressed_o), 0);
        wait_to(t0 + 18);
        chk("t1_pressed_e18", int'(bif.pressed_o), 1);
        chk("t1_pulse_e18", int'(bif.pulse_o), 1);
        wait_to(t0 + 19);
        chk("t1_pulse_e19", int'(bif.pulse_o), 1);
        wait_to(t0 + 20);
        chk("t1_pulse_e20", int'(bif.pulse_o), 0);
        wait_to(t0 + 100);
        t1 = cyc;
        bif.button_i = 1'b0;
        wait_to(t1 + 30);
        chk("t1_npulses", starts.size(), 1);
        chk("t1_start", q_at(starts, 0) - t0, 18);
        chk("t1_width", hi_cnt, 2);
        chk("t1_fall", q_at(falls, 0) - t1, 18);
        clear_mon();

        // 2: bounce every 3 cycles, then stable press
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            bif.button_i = (i % 2 == 0);
            wait_to(t0 + 3 * (i + 1));
        end
        t1 = cyc;
        bif.button_i = 1'b1;
        wait_to(t1 + 17);
        chk("t2_no_pulse_yet", starts.size(), 0);
        wait_to(t1 + 50);
        chk("t2_npulses", starts.size(), 1);
        chk("t2_start", q_at(starts, 0) - t1, 18);
        chk("t2_width", hi_cnt, 2);
        bif.button_i = 1'b0;
        wait_to(cyc + 30);
        clear_mon();

        // 3: 15-cycle glitch rejected, 16-cycle glitch accepted
        t0 = cyc;
        bif.button_i = 1'b1;
        wait_to(t0 + 15);
        bif.button_i = 1'b0;
        wait_to(t0 + 50);
        chk("t3_g15_pulses", starts.size(), 0);
        chk("t3_g15_rises", rises.size(), 0);
        t0 = cyc;
        bif.button_i = 1'b1;
        wait_to(t0 + 16);
        bif.button_i = 1'b0;
        wait_to(t0 + 60);
        chk("t3_g16_pulses", starts.size(), 1);
        chk("t3_g16_width", hi_cnt, 2);
        chk("t3_g16_start", q_at(starts, 0) - t0, 18);
        chk("t3_g16_pr_len", q_at(falls, 0) - q_at(rises, 0), 16);
        clear_mon();

        // 4: auto-repeat while held from edge 0 to edge 200
        bif.repeat_en_i = 1'b1;
        wait_to(cyc + 2);
        t0 = cyc;
        bif.button_i = 1'b1;
        wait_to(t0 + 200);
        bif.button_i = 1'b0;
        wait_to(t0 + 260);
        chk("t4_npulses", starts.size(), 10);
        chk("t4_start0", q_at(starts, 0) - t0, 18);
        for (int i = 1; i < 10; i++) begin
            chk($sformatf("t4_start%0d", i), q_at(starts, i) - t0, 82 + 16 * (i - 1));
        end
        chk("t4_width", hi_cnt, 20);
        chk("t4_fall", q_at(falls, 0) - t0, 218);
        bif.repeat_en_i = 1'b0;
        clear_mon();

        // 5: async reset mid-pulse with button held
        t0 = cyc;
        bif.button_i = 1'b1;
        wait_to(t0 + 18);
        chk("t5_pulse_before", int'(bif.pulse_o), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_pulse_async", int'(bif.pulse_o), 0);
        chk("t5_pressed_async", int'(bif.pressed_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rr = cyc;
        clear_mon();
        wait_to(rr + 17);
        chk("t5_pressed_e17", int'(bif.pressed_o), 0);
        wait_to(rr + 30);
        chk("t5_npulses", starts.size(), 1);
        chk("t5_start", q_at(starts, 0) - rr, 18);
        bif.button_i = 1'b0;
        wait_to(cyc + 30);
        clear_mon();

        // 6: repeat disabled for 40 cycles after the 2nd repeat
        bif.repeat_en_i = 1'b1;
        wait_to(cyc + 2);
        t0 = cyc;
        bif.button_i = 1'b1;
        wait_to(t0 + 100);
        bif.repeat_en_i = 1'b0;
        wait_to(t0 + 140);
        chk("t6_pulses_disabled", starts.size(), 3);
        bif.repeat_en_i = 1'b1;
        wait_to(t0 + 210);
        bif.button_i = 1'b0;
        wait_to(t0 + 260);
        chk("t6_npulses", starts.size(), 5);
        chk("t6_start2", q_at(starts, 2) - t0, 98);
        chk("t6_reen_start", q_at(starts, 3) - t0, 205);
        chk("t6_next_start", q_at(starts, 4) - t0, 221);
        chk("t6_fall", q_at(falls, 0) - t0, 228);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
